// File: rtl/lsu_mem_responder_if.sv
// Request/response handshake and word-wide data-memory port of the LSU memory responder.
// The slave modport is the responder; the master modport is the LSU plus data RAM side.
interface lsu_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_zero_ext;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_load, req_zero_ext, req_size, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_is_load, req_zero_ext, req_size, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// LSU memory responder: one load/store at a time against a word-wide synchronous RAM
// with byte enables; misaligned or illegal-size requests answer with an error only.
module lsu_mem_responder #(
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic        zext_q, zext_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_illegal = 1'b0;
            2'b01:   is_illegal = off[0];
            2'b10:   is_illegal = (off != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Lane select plus sign/zero extension of the returned RAM word.
    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] size,
                                            input logic [1:0] off, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   extract = {{24{b[7] & ~zext}}, b};
            2'b01:   extract = {{16{h[15] & ~zext}}, h};
            default: extract = rd;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        zext_d       = zext_q;
        size_d       = size_q;
        off_d        = off_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'b0000;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_load_d = bus.req_is_load;
                    zext_d    = bus.req_zero_ext;
                    size_d    = bus.req_size;
                    off_d     = bus.req_addr[1:0];
                    if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else begin
                        // Memory strobes are registered, so they are set up here to appear in ACCESS.
                        state_d    = ACCESS;
                        mem_en_d   = 1'b1;
                        mem_we_d   = !bus.req_is_load;
                        mem_be_d   = bus.req_is_load ? 4'b1111
                                                     : store_be(bus.req_size, bus.req_addr[1:0]);
                        mem_addr_d = bus.req_addr[31:2];
                        if (!bus.req_is_load) begin
                            mem_wdata_d = store_data(bus.req_size, bus.req_wdata);
                        end
                    end
                end
            end
            ACCESS: begin
                if (is_load_q) begin
                    state_d = WAIT;
                    cnt_d   = 3'(MEM_LAT - 1);
                end else begin
                    state_d      = RESP;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d      = RESP;
                    resp_rdata_d = extract(bus.mem_rdata, size_q, off_q, zext_q);
                    resp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            is_load_q    <= 1'b0;
            zext_q       <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            zext_q       <= zext_d;
            size_q       <= size_d;
            off_q        <= off_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: directed vector table, backpressure and reset sequences,
// then random traffic against a word-array reference model of the data RAM.
module tb_lsu_mem_responder;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_responder_if bus();

    lsu_mem_responder #(.MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data RAM environment: byte-enabled writes, reads returned MEM_LAT cycles later.
    logic [31:0] tb_mem  [16];
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) tb_mem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? tb_mem[bus.mem_addr[3:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    int          got_nen;
    logic [3:0]  got_be;
    logic        got_we;
    logic [31:0] got_wdo;
    logic [29:0] got_mad;

    logic [31:0] ref_mem [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on whole words.
    function automatic logic ref_illegal(input logic [1:0] sz, input logic [31:0] ad);
        if (sz == 2'd3) return 1'b1;
        return (ad % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic zx);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!zx && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!zx && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 32'hFF << (8 * off);
        if (sz == 2'd1) return 32'hFFFF << (8 * off);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdo(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic run_txn(input logic ld, input logic zx, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd, input int hold);
        int cyc;
        bus.resp_ready   = (hold == 0);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = ld;
        bus.req_zero_ext = zx;
        bus.req_size     = sz;
        bus.req_addr     = ad;
        bus.req_wdata    = wd;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        got_nen = 0; got_be = '0; got_we = 1'b0; got_wdo = '0; got_mad = '0;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_is_load  = 1'($urandom);
        bus.req_zero_ext = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        cyc = 1;
        while (1) begin
            if (bus.mem_en) begin
                got_nen++;
                got_be  = bus.mem_be;
                got_we  = bus.mem_we;
                got_wdo = bus.mem_wdata;
                got_mad = bus.mem_addr;
            end
            if (bus.resp_valid || cyc >= 40) break;
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        got_lat = cyc;
        chk("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        got_rd  = bus.resp_rdata;
        got_err = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_rdata", bus.resp_rdata, got_rd);
            chk("bp_resp_err", 32'(bus.resp_err), 32'(got_err));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_mem_en", 32'(bus.mem_en), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_hs", 32'(bus.req_ready), 32'd1);
        chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_txn(input logic ld, input logic zx, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd, input int hold,
                             input logic e_err, input logic [31:0] e_rd,
                             input logic [3:0] e_be, input logic [31:0] e_wdo);
        int e_lat;
        run_txn(ld, zx, sz, ad, wd, hold);
        e_lat = e_err ? 1 : (ld ? 2 + MEM_LAT : 2);
        chk("resp_err", 32'(got_err), 32'(e_err));
        chk("resp_rdata", got_rd, e_rd);
        chk("latency", got_lat, e_lat);
        chk("mem_en_count", got_nen, e_err ? 0 : 1);
        if (!e_err) begin
            chk("mem_be", 32'(got_be), 32'(e_be));
            chk("mem_we", 32'(got_we), 32'(!ld));
            chk("mem_addr", 32'(got_mad), ad >> 2);
            if (!ld) chk("mem_wdata", got_wdo, e_wdo);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    endtask

    typedef struct packed {
        logic        ld;
        logic        zx;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wdo;
    } vec_t;

    vec_t tbl [20];

    initial begin
        //           ld    zx    sz     addr          wdata          err   rdata          be     wdata_out
        tbl[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h8001_1234, 1'b0, 32'h0000_0000, 4'hF, 32'h8001_1234};
        tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0,         1'b0, 32'hFFFF_8001, 4'hF, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'h0,         1'b0, 32'h0000_8001, 4'hF, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 32'h0000_0000, 4'h8, 32'hDDDD_DDDD};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         1'b0, 32'hDD01_1234, 4'hF, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h7F80_01FF, 1'b0, 32'h0000_0000, 4'hF, 32'h7F80_01FF};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 32'h0000_3000, 32'h0,         1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 32'h0000_3001, 32'h0,         1'b0, 32'h0000_0001, 4'hF, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 32'h0000_3002, 32'h0,         1'b0, 32'hFFFF_FF80, 4'hF, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 32'h0000_3003, 32'h0,         1'b0, 32'h0000_007F, 4'hF, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 32'h0000_3002, 32'h0,         1'b0, 32'h0000_0080, 4'hF, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 2'd2, 32'h0000_3000, 32'h0,         1'b0, 32'h7F80_01FF, 4'hF, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 2'd1, 32'h0000_3002, 32'h1234_ABCD, 1'b0, 32'h0000_0000, 4'hC, 32'hABCD_ABCD};
        tbl[13] = '{1'b1, 1'b0, 2'd1, 32'h0000_3002, 32'h0,         1'b0, 32'hFFFF_ABCD, 4'hF, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 2'd1, 32'h0000_3000, 32'h0,         1'b0, 32'h0000_01FF, 4'hF, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 2'd2, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000, 4'h0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 4'h0, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 2'd1, 32'h0000_0001, 32'h1111_2222, 1'b1, 32'h0000_0000, 4'h0, 32'h0};
        tbl[18] = '{1'b0, 1'b0, 2'd0, 32'h0000_3001, 32'h0000_0055, 1'b0, 32'h0000_0000, 4'h2, 32'h5555_5555};
        tbl[19] = '{1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0,         1'b0, 32'hABCD_55FF, 4'hF, 32'h0};

        bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_zero_ext = 1'b0;
        bus.req_size = 2'd0; bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            check_txn(tbl[i].ld, tbl[i].zx, tbl[i].sz, tbl[i].ad, tbl[i].wd, 0,
                      tbl[i].err, tbl[i].rd, tbl[i].be, tbl[i].wdo);
        end

        // Consumer stalls for several cycles on a load response.
        check_txn(1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 5, 1'b0, 32'hABCD_55FF, 4'hF, 32'h0);

        // Reset in the middle of a load's wait phase.
        bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'h0000_3000; bus.req_zero_ext = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check_txn(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D);

        // Random traffic: establish known RAM contents, then mixed requests.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ad, wd;
            ad = ($urandom & 32'hFFFF_FFC0) | 32'(i * 4);
            wd = $urandom;
            ref_mem[i] = wd;
            check_txn(1'b0, 1'b0, 2'd2, ad, wd, 0, 1'b0, 32'h0, 4'hF, wd);
        end
        for (int n = 0; n < 150; n++) begin
            logic        ld, zx, e_err;
            logic [1:0]  sz, off;
            logic [31:0] ad, wd, e_rd, e_wdo, m;
            logic [3:0]  e_be;
            ld  = 1'($urandom);
            zx  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            ad  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            wd  = $urandom;
            off = ad[1:0];
            e_err = ref_illegal(sz, ad);
            e_rd  = (!e_err && ld) ? ref_load(ref_mem[ad[5:2]], sz, off, zx) : 32'h0;
            e_be  = ld ? 4'hF : ref_be(sz, off);
            e_wdo = ref_wdo(sz, wd);
            check_txn(ld, zx, sz, ad, wd, $urandom_range(0, 3), e_err, e_rd, e_be, e_wdo);
            if (!e_err && !ld) begin
                m = ref_mask(sz, off);
                ref_mem[ad[5:2]] = (ref_mem[ad[5:2]] & ~m) | ((wd << (8 * off)) & m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Memory-side responder for the load/store unit: accepts one decoded load/store request at a time (direction, size, zero-extend flag, byte address, store data) and drives a word-wide synchronous data memory with byte enables. For loads it returns the selected byte/half/word, sign- or zero-extended to 32 bits. It checks alignment and responds with an error instead of touching memory. It sits between the execution-stage address generation and the data RAM.

## Interface
- MEM_LAT, 2, cycles from the read-enable cycle to valid `mem_rdata`; legal range 1..8

- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_is_load  in  1  1 = load, 0 = store
- req_zero_ext  in  1  1 = zero-extend load data (LBU/LHU); ignored for word and store
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  30  word address = latched req_addr[31:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid in cycle t+MEM_LAT for a read strobe in cycle t

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid && req_ready`, latch all req_* fields. If the request is illegal, go to RESP with err=1 and rdata=0, with no memory access. Illegal means size 11, half with addr[0]=1, or word with addr[1:0]≠0. Otherwise go to ACCESS.
- ACCESS, one cycle: mem_en=1, mem_we=!is_load, mem_be driven.
  - Loads: mem_be=1111.
  - Byte stores: be = 0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half stores: be = addr[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
  - Word stores: be=1111, wdata unchanged.
  - Store goes to RESP with rdata=0, err=0. Load goes to WAIT with counter loaded to MEM_LAT-1.
- WAIT: counter decrements each cycle. In the cycle where counter==0, `mem_rdata` is valid. Capture the extracted data at that edge and go to RESP.
- Extraction:
  - Byte: mem_rdata[8*addr[1:0] +: 8].
  - Half: mem_rdata[16*addr[1] +: 16].
  - Upper bits are copies of the MSB, or zero if zero_ext.
  - Word: mem_rdata as-is.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until `resp_ready`. On `resp_valid && resp_ready`, go to IDLE. Backpressure of any length is legal.
- Outside ACCESS: mem_en=0, mem_we=0, mem_be=0. mem_addr and mem_wdata hold their last values.
- resp_rdata and resp_err are registered, and change only on entry to RESP.

## Timing
- Request accepted at edge E0 (handshake in cycle 0).
- Error: resp_valid in cycle 1.
- Store: ACCESS in cycle 1, resp_valid in cycle 2.
- Load: ACCESS in cycle 1, rdata valid in cycle 1+MEM_LAT, resp_valid in cycle 2+MEM_LAT.
- Next request can be accepted in the cycle after the response handshake. No overlap. req_ready=0 from ACCESS through RESP.
- Reset values (asserted asynchronously, held during reset): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.
- Reset mid-transaction: the transaction is abandoned with no response. A pending mem_rdata is ignored. First acceptance is possible in the first cycle after rst_n rises.
- req_* inputs are sampled only at the acceptance edge. Changes afterwards have no effect.

## Test plan
- Store byte, addr=0x1003, wdata=0xAABBCCDD → cycle 1: mem_en=1, mem_we=1, mem_be=1000, mem_addr=0x400, mem_wdata=0xDDDDDDDD; cycle 2: resp_valid=1, rdata=0, err=0.
- Load half, MEM_LAT=2, addr=0x2002, mem_rdata=0x8001_1234: signed gives rdata=0xFFFF8001; zero_ext=1 gives 0x00008001. resp_valid rises in cycle 4.
- Load byte, addr lanes 0..3, mem_rdata=0x7F80_01FF, signed → 0xFFFFFFFF, 0x00000001, 0xFFFFFF80, 0x0000007F.
- Misaligned word at addr=0x0006, and size=11 → resp_err=1, rdata=0 in cycle 1; mem_en never asserted.
- Backpressure: resp_ready held low 5 cycles on a load → resp_valid/rdata stable, req_ready=0 throughout; accepted on release, IDLE next cycle.
- rst_n pulsed low during WAIT → all outputs at reset values immediately; no resp_valid afterwards. A new store after reset completes normally in 2 cycles.
